iir_fold_scheduler: RTL
=======================

# iir_fold_scheduler

Control sequencer for the 3-folded IIR filter datapath. It accepts one input sample per handshake and steps the shared multiplier/accumulator through FOLD coefficient phases. It drives the coefficient/operand mux select, accumulator clear/enable and delay-register write strobes, then presents the result with a valid/ready handshake. It replaces the free-running phase counter with a phase schedule that stalls when idle and starts on a sample handshake.

## Interface
- FOLD, 3: folding factor (number of time-multiplexed taps per sample), legal range 2..8
- PW, $clog2(FOLD): width of phase/select outputs (derived, not overridden)
- CNTW, 16: width of processed-sample counter
- clk  in  1  rising-edge clock, the single clock domain
- rst  in  1  synchronous active-high reset
- in_valid  in  1  upstream sample available
- in_ready  out  1  scheduler can accept a sample
- sample_le  out  1  load enable for datapath input register
- phase  out  PW  current fold phase, 0..FOLD-1 (mux/coef select)
- mac_clr  out  1  clear accumulator (first phase)
- mac_en  out  1  accumulate enable
- out_valid  out  1  filtered result valid
- out_ready  in  1  downstream accepts result
- state_we  out  1  write enable for IIR delay (state) registers
- sample_cnt  out  CNTW  number of completed output handshakes, wraps

## Operation
- FSM states: IDLE, RUN, DONE (one-hot or binary, implementer's choice).
- IDLE: in_ready=1. in_valid&in_ready → sample_le=1 same cycle, next state RUN, phase←0.
- RUN: mac_en=1 every cycle; mac_clr=1 only when phase==0; phase increments by 1 per cycle. When phase==FOLD-1, next state DONE and phase←0 (no wrap past FOLD-1).
- DONE: out_valid=1, phase holds 0, mac_en=0. state_we=out_valid&out_ready (single cycle). On handshake: sample_cnt increments (wraps 2^CNTW-1→0), next state IDLE.
- in_ready=0 in RUN and DONE; in_valid during those states is ignored (upstream holds it).
- Reset (any state, any phase): next edge state=IDLE, phase=0, sample_cnt=0; partial MAC result discarded, no state_we issued.
- Reset values / while rst=1: in_ready=0, sample_le=0, phase=0, mac_clr=0, mac_en=0, out_valid=0, state_we=0, sample_cnt=0.

## Timing
- Accept at cycle t; RUN phases 0..FOLD-1 at t+1..t+FOLD; out_valid first high at t+FOLD+1.
- Latency accept→out_valid: FOLD+1 cycles. With out_ready tied 1, throughput one sample per FOLD+2 cycles (in_ready high at t+FOLD+2).
- out_valid held stable until out_ready; phase, mac_* inactive during stall.
- All outputs are functions of registered state only (in_ready not combinationally dependent on in_valid); sample_le and state_we are the only outputs that AND in an input.

## Configuration
- IIR_SCHED_BACKPRESSURE_EN defined: out_ready honoured as above; DONE lasts until handshake.
- Not defined: out_ready port remains but is ignored; DONE lasts exactly one cycle, state_we=1 and sample_cnt increments in that cycle unconditionally.

## Structure
- Package iir_fold_pkg: state enum (IDLE/RUN/DONE), default FOLD constant, PW width function, CNTW default.
- One sub-module: fold_phase_counter (modulo-FOLD counter with synchronous clear and enable, terminal-count output); FSM and handshake logic in the top.

## Test plan
- Reset then idle: rst 2 cycles, in_valid=0 → in_ready=1 from first cycle after rst, all other outputs 0, phase=0 indefinitely.
- Single sample, FOLD=3, out_ready=1: in_valid at t → sample_le at t, phase 0,1,2 at t+1..t+3 with mac_clr only at t+1, out_valid and state_we at t+4, sample_cnt=1, in_ready at t+5.
- Backpressure (macro defined): out_ready=0 for 5 cycles after out_valid → out_valid held, state_we=0, sample_cnt unchanged; out_ready=1 → one state_we pulse, cnt+1.
- Backpressure disabled (macro undefined): out_ready=0 → out_valid and state_we single-cycle pulse at t+4, sample_cnt increments anyway.
- Reset mid-RUN at phase 1: rst one cycle → next cycle IDLE, phase=0, no out_valid/state_we, sample_cnt=0; new sample afterwards completes normally.
- Counter wrap, CNTW=4, continuous in_valid/out_ready: 17 samples → sample_cnt reads 15 then 0 then 1; in_ready never high during RUN/DONE.

Source files
------------

// File: rtl/iir_fold_pkg.sv
// Shared types and defaults for the folded IIR scheduler.
// Holds the scheduler state enum and the phase-width helper.
package iir_fold_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sched_state_t;

  localparam int FOLD_DEFAULT = 3;
  localparam int CNTW_DEFAULT = 16;

  // Phase select width; never narrower than one bit.
  function automatic int phase_width(input int fold);
    return (fold <= 2) ? 1 : $clog2(fold);
  endfunction

endpackage

// File: rtl/iir_fold_scheduler_phase_counter.sv
// Modulo-FOLD phase counter with synchronous reset/clear, enable and a
// terminal-count flag that is high while the count sits on FOLD-1.
module fold_phase_counter
  import iir_fold_pkg::*;
#(
  parameter int FOLD = FOLD_DEFAULT,
  localparam int PW = phase_width(FOLD)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [PW-1:0] count,
  output logic          tc
);

  localparam logic [PW-1:0] LAST = PW'(FOLD - 1);

  assign tc = (count == LAST);

  // Wraps to zero after the last phase, so the count is already 0 when the
  // sequencer leaves the run state.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + PW'(1);
    end
  end

endmodule

// File: rtl/iir_fold_scheduler.sv
// Control sequencer for the FOLD-way time-multiplexed IIR datapath.
// Optional macro IIR_SCHED_BACKPRESSURE_EN makes the result wait for out_ready.
module iir_fold_scheduler
  import iir_fold_pkg::*;
#(
  parameter int FOLD = FOLD_DEFAULT,
  parameter int CNTW = CNTW_DEFAULT,
  localparam int PW = phase_width(FOLD)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            sample_le,
  output logic [PW-1:0]   phase,
  output logic            mac_clr,
  output logic            mac_en,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            state_we,
  output logic [CNTW-1:0] sample_cnt
);

  sched_state_t state;
  logic         accept;
  logic         out_fire;
  logic         run_last;
  logic         run_active;

  assign accept     = in_valid & in_ready;
  assign sample_le  = accept;
  assign run_active = (state == RUN);

`ifdef IIR_SCHED_BACKPRESSURE_EN
  assign out_fire = out_valid & out_ready;
`else
  // Without backpressure the result slot is a fixed single-cycle pulse.
  logic unused_out_ready;
  assign unused_out_ready = out_ready;
  assign out_fire         = out_valid;
`endif

  assign state_we = out_fire;

  fold_phase_counter #(
    .FOLD (FOLD)
  ) u_phase (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept),
    .en    (run_active),
    .count (phase),
    .tc    (run_last)
  );

  // Handshake outputs are registered one step ahead of the state they
  // describe, so each is valid in the same cycle as the state it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      mac_clr    <= 1'b0;
      mac_en     <= 1'b0;
      out_valid  <= 1'b0;
      sample_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (accept) begin
            state    <= RUN;
            in_ready <= 1'b0;
            mac_clr  <= 1'b1;
            mac_en   <= 1'b1;
          end
        end
        RUN: begin
          mac_clr <= 1'b0;
          if (run_last) begin
            state     <= DONE;
            mac_en    <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_fire) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            in_ready   <= 1'b1;
            sample_cnt <= sample_cnt + CNTW'(1);
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          mac_clr   <= 1'b0;
          mac_en    <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
